// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage behind execute.
// Issues loads/stores over a req/ack data-memory port. It steers store bytes
// into lanes, extracts and extends load data, and produces a registered
// writeback bundle.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When defined, misaligned
// half/word accesses skip the bus and return a one-cycle misalign flag.
module mem_access #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            misalign
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d;
  logic            kill_q, kill_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misalign_q, misalign_d;

  logic            mem_op;
  logic            mis;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;

  // Sign-extend a byte to the datapath width.
  function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] b);
    logic signed [XLEN-1:0] r;
    r = b;
    return r;
  endfunction

  // Sign-extend a halfword to the datapath width.
  function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] h);
    logic signed [XLEN-1:0] r;
    r = h;
    return r;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  // Unused funct3 codes (011/110/111) return the whole word.
  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w,
                                                   input logic [1:0]      off,
                                                   input logic [2:0]      f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return sext8(b);
      3'b001:  return sext16(h);
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // Store lane steering: byte enables and replicated write data.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr[1:0];
        lane_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        lane_be    = addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_op = mem_read | mem_write;

  // Misalignment detection; funct3[1] set means a word access.
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = ((funct3[1:0] == 2'b01) && addr[0]) ||
               (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Next-state and register-input logic for the IDLE/ACCESS controller.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    be_d           = be_q;
    f3_d           = f3_q;
    rd_d           = rd_q;
    rw_d           = rw_q;
    kill_d         = kill_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_data_d      = wb_data_q;
    misalign_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A flush in the acceptance cycle simply drops the instruction.
        if (ex_valid && !flush) begin
          if (mem_op && mis) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd_in;
            wb_reg_write_d = 1'b0;
            wb_data_d      = addr;
            misalign_d     = 1'b1;
          end else if (mem_op) begin
            // A simultaneous read and write is treated as a load.
            we_d    = mem_write & ~mem_read;
            be_d    = (mem_write & ~mem_read) ? lane_be : 4'b0000;
            wdata_d = lane_wdata;
            addr_d  = addr;
            f3_d    = funct3;
            rd_d    = rd_in;
            rw_d    = reg_write_in;
            kill_d  = 1'b0;
            state_d = ACCESS;
          end else begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = rd_in;
            wb_reg_write_d = reg_write_in;
            wb_data_d      = addr;
          end
        end
      end
      ACCESS: begin
        // A flush here lets the bus transaction finish but kills writeback.
        if (flush) kill_d = 1'b1;
        if (dmem_ack) begin
          state_d        = IDLE;
          wb_valid_d     = ~(kill_q | flush);
          wb_rd_d        = rd_q;
          wb_reg_write_d = rw_q & ~we_q;
          wb_data_d      = we_q ? addr_q : load_extract(dmem_rdata, addr_q[1:0], f3_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and bundle registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      be_q           <= 4'b0000;
      f3_q           <= 3'b000;
      rd_q           <= 5'd0;
      rw_q           <= 1'b0;
      kill_q         <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      be_q           <= be_d;
      f3_q           <= f3_d;
      rd_q           <= rd_d;
      rw_q           <= rw_d;
      kill_q         <= kill_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign stall        = ex_valid & ~ex_ready;
  assign dmem_req     = (state_q == ACCESS);
  assign dmem_we      = dmem_req & we_q;
  assign dmem_be      = dmem_req ? be_q : 4'b0000;
  assign dmem_addr    = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign misalign     = misalign_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access; honours MEM_MISALIGN_TRAP_EN if defined.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        reg_write_in, flush;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        stall, misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3), .addr(addr),
    .store_data(store_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .stall(stall), .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one load/store with the upstream holding ex_valid while stalled.
  task automatic mem_op(input string nm, input logic [31:0] a, input logic [31:0] sd,
                        input logic [2:0] f3, input logic mr, input logic mw,
                        input logic rwin, input int dly, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic exp_we,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_wb, input logic exp_rw);
    ex_valid = 1'b1; addr = a; store_data = sd; funct3 = f3;
    mem_read = mr; mem_write = mw; rd_in = 5'd9; reg_write_in = rwin;
    check({nm, "_ready"}, ex_ready, 1'b1);
    check({nm, "_nostall"}, stall, 1'b0);
    tick();
    check({nm, "_req"}, dmem_req, 1'b1);
    check({nm, "_addr"}, dmem_addr, exp_addr);
    check({nm, "_we"}, dmem_we, exp_we);
    check({nm, "_be"}, dmem_be, exp_be);
    if (exp_we) check({nm, "_wdata"}, dmem_wdata, exp_wd);
    check({nm, "_wbv0"}, wb_valid, 1'b0);
    check({nm, "_stall"}, stall, 1'b1);
    for (int i = 0; i < dly; i++) begin
      dmem_ack = 1'b0;
      tick();
      check({nm, "_req_hold"}, dmem_req, 1'b1);
      check({nm, "_addr_hold"}, dmem_addr, exp_addr);
      check({nm, "_stall_hold"}, stall, 1'b1);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    check({nm, "_wbv"}, wb_valid, 1'b1);
    check({nm, "_wbdata"}, wb_data, exp_wb);
    check({nm, "_wbrw"}, wb_reg_write, exp_rw);
    check({nm, "_wbrd"}, wb_rd, 5'd9);
    check({nm, "_req_off"}, dmem_req, 1'b0);
    check({nm, "_misalign"}, misalign, 1'b0);
    tick();
    check({nm, "_wbv_pulse"}, wb_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = '0; store_data = '0; rd_in = '0;
    reg_write_in = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_req", dmem_req, 1'b0);
    check("rst_wbv", wb_valid, 1'b0);
    check("rst_wbdata", wb_data, 32'h0);
    check("rst_daddr", dmem_addr, 32'h0);
    check("rst_be", dmem_be, 4'h0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_ready", ex_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Non-memory pass-through
    ex_valid = 1'b1; addr = 32'h0000_1234; rd_in = 5'd5; reg_write_in = 1'b1;
    check("alu_stall", stall, 1'b0);
    tick();
    ex_valid = 1'b0;
    check("alu_wbv", wb_valid, 1'b1);
    check("alu_wbdata", wb_data, 32'h0000_1234);
    check("alu_wbrd", wb_rd, 5'd5);
    check("alu_wbrw", wb_reg_write, 1'b1);
    tick();
    check("alu_wbv_pulse", wb_valid, 1'b0);

    // Loads with sign/zero extension
    mem_op("lb",  32'h103, 0, 3'b000, 1, 0, 1, 2, 32'h8000_0000, 32'h100, 0, 4'h0, 0, 32'hFFFF_FF80, 1);
    mem_op("lbu", 32'h103, 0, 3'b100, 1, 0, 1, 2, 32'h8000_0000, 32'h100, 0, 4'h0, 0, 32'h0000_0080, 1);
    mem_op("lh",  32'h102, 0, 3'b001, 1, 0, 1, 0, 32'h8001_0000, 32'h100, 0, 4'h0, 0, 32'hFFFF_8001, 1);
    mem_op("lhu", 32'h106, 0, 3'b101, 1, 0, 1, 1, 32'h8001_0000, 32'h104, 0, 4'h0, 0, 32'h0000_8001, 1);
    mem_op("lwrw", 32'h108, 32'h1, 3'b010, 1, 1, 1, 0, 32'hCAFE_F00D, 32'h108, 0, 4'h0, 0, 32'hCAFE_F00D, 1);

    // Stores
    mem_op("sh", 32'h202, 32'hDEAD_BEEF, 3'b001, 0, 1, 1, 0, 0, 32'h200, 1, 4'b1100, 32'hBEEF_BEEF, 32'h202, 0);
    mem_op("sb", 32'h201, 32'h1234_56A5, 3'b000, 0, 1, 0, 1, 0, 32'h200, 1, 4'b0010, 32'hA5A5_A5A5, 32'h201, 0);
    mem_op("sw", 32'h20C, 32'h0BAD_CAFE, 3'b010, 0, 1, 0, 0, 0, 32'h20C, 1, 4'b1111, 32'h0BAD_CAFE, 32'h20C, 0);

    // Flush in IDLE drops the instruction
    ex_valid = 1'b1; addr = 32'h77; rd_in = 5'd3; reg_write_in = 1'b1; flush = 1'b1;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    check("flidle_wbv", wb_valid, 1'b0);

    // Flush in ACCESS: bus completes, writeback suppressed, then back-to-back ALU op
    ex_valid = 1'b1; addr = 32'h400; funct3 = 3'b010; mem_read = 1'b1; rd_in = 5'd9;
    tick();
    check("flacc_req", dmem_req, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flacc_req_hold", dmem_req, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_ack = 1'b0; mem_read = 1'b0;
    check("flacc_wbv", wb_valid, 1'b0);
    check("flacc_req_off", dmem_req, 1'b0);
    check("flacc_ready", ex_ready, 1'b1);
    addr = 32'h55; rd_in = 5'd7; reg_write_in = 1'b1;
    tick();
    ex_valid = 1'b0;
    check("b2b_wbv", wb_valid, 1'b1);
    check("b2b_wbdata", wb_data, 32'h55);
    check("b2b_wbrd", wb_rd, 5'd7);

    // Reset mid-transaction
    ex_valid = 1'b1; addr = 32'h500; funct3 = 3'b010; mem_read = 1'b1;
    tick();
    check("rstmid_req", dmem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req_async", dmem_req, 1'b0);
    check("rstmid_ready", ex_ready, 1'b1);
    ex_valid = 1'b0; mem_read = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_wbv", wb_valid, 1'b0);
      check("rstmid_req_idle", dmem_req, 1'b0);
    end

    // Misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
    ex_valid = 1'b1; addr = 32'h301; funct3 = 3'b010; mem_read = 1'b1;
    rd_in = 5'd9; reg_write_in = 1'b1;
    tick();
    ex_valid = 1'b0; mem_read = 1'b0;
    check("mis_req", dmem_req, 1'b0);
    check("mis_flag", misalign, 1'b1);
    check("mis_wbv", wb_valid, 1'b1);
    check("mis_wbrw", wb_reg_write, 1'b0);
    check("mis_wbdata", wb_data, 32'h301);
    tick();
    check("mis_flag_pulse", misalign, 1'b0);
    check("mis_wbv_pulse", wb_valid, 1'b0);
`else
    mem_op("lwmis", 32'h301, 0, 3'b010, 1, 0, 1, 1, 32'h1234_5678, 32'h300, 0, 4'h0, 0, 32'h1234_5678, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
